// File: rtl/control_vector_stage_reg.sv
// ============================================================================
// control_vector_stage_reg : decode->execute control-vector pipeline register
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module control_vector_stage_reg (
  input  logic clk,
  input  logic rst_n,
  input  logic nop,
  input  logic in_PC_LD,
  input  logic in_PC_INC,
  input  logic in_PC_MUX_SEL,
  input  logic in_SP_LD,
  input  logic in_SP_INCR,
  input  logic in_SP_DECR,
  input  logic in_RF_WR,
  input  logic in_RF_WR_SEL,
  input  logic in_ALU_OPY_SEL,
  input  logic in_ALU_SEL,
  input  logic in_SCR_WE,
  input  logic in_SCR_DATA_SE,
  input  logic in_SCR_ADDR_SE,
  input  logic in_FLG_C_SET,
  input  logic in_FLG_C_CLR,
  input  logic in_FLG_C_LD,
  input  logic in_FLG_Z_LD,
  input  logic in_FLG_LD_SEL,
  input  logic in_FLG_SHAD_LD,
  input  logic in_I_SET,
  input  logic in_I_CLR,
  input  logic in_IO_STRB,
  input  logic in_BRANCH_TYPE,
  input  logic in_rst,
  output logic out_PC_LD,
  output logic out_PC_INC,
  output logic out_PC_MUX_SEL,
  output logic out_SP_LD,
  output logic out_SP_INCR,
  output logic out_SP_DECR,
  output logic out_RF_WR,
  output logic out_RF_WR_SEL,
  output logic out_ALU_OPY_SEL,
  output logic out_ALU_SEL,
  output logic out_SCR_WE,
  output logic out_SCR_DATA_SE,
  output logic out_SCR_ADDR_SE,
  output logic out_FLG_C_SET,
  output logic out_FLG_C_CLR,
  output logic out_FLG_C_LD,
  output logic out_FLG_Z_LD,
  output logic out_FLG_LD_SEL,
  output logic out_FLG_SHAD_LD,
  output logic out_I_SET,
  output logic out_I_CLR,
  output logic out_IO_STRB,
  output logic out_BRANCH_TYPE,
  output logic out_rst
);

  localparam int unsigned C_VEC_W = 24;

  logic [C_VEC_W-1:0] in_vec;
  logic [C_VEC_W-1:0] vec_d;
  logic [C_VEC_W-1:0] vec_q;

  always_comb begin
    in_vec = {in_rst,         in_BRANCH_TYPE, in_IO_STRB,     in_I_CLR,
              in_I_SET,       in_FLG_SHAD_LD, in_FLG_LD_SEL,  in_FLG_Z_LD,
              in_FLG_C_LD,    in_FLG_C_CLR,   in_FLG_C_SET,   in_SCR_ADDR_SE,
              in_SCR_DATA_SE, in_SCR_WE,      in_ALU_SEL,     in_ALU_OPY_SEL,
              in_RF_WR_SEL,   in_RF_WR,       in_SP_DECR,     in_SP_INCR,
              in_SP_LD,       in_PC_MUX_SEL,  in_PC_INC,      in_PC_LD};
    // A bubble squashes every strobe, including the carried CPU reset request
    vec_d  = nop ? '0 : in_vec;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec_q <= '0;
    end else begin
      vec_q <= vec_d;
    end
  end

  assign out_PC_LD       = vec_q[0];
  assign out_PC_INC      = vec_q[1];
  assign out_PC_MUX_SEL  = vec_q[2];
  assign out_SP_LD       = vec_q[3];
  assign out_SP_INCR     = vec_q[4];
  assign out_SP_DECR     = vec_q[5];
  assign out_RF_WR       = vec_q[6];
  assign out_RF_WR_SEL   = vec_q[7];
  assign out_ALU_OPY_SEL = vec_q[8];
  assign out_ALU_SEL     = vec_q[9];
  assign out_SCR_WE      = vec_q[10];
  assign out_SCR_DATA_SE = vec_q[11];
  assign out_SCR_ADDR_SE = vec_q[12];
  assign out_FLG_C_SET   = vec_q[13];
  assign out_FLG_C_CLR   = vec_q[14];
  assign out_FLG_C_LD    = vec_q[15];
  assign out_FLG_Z_LD    = vec_q[16];
  assign out_FLG_LD_SEL  = vec_q[17];
  assign out_FLG_SHAD_LD = vec_q[18];
  assign out_I_SET       = vec_q[19];
  assign out_I_CLR       = vec_q[20];
  assign out_IO_STRB     = vec_q[21];
  assign out_BRANCH_TYPE = vec_q[22];
  assign out_rst         = vec_q[23];

endmodule

`default_nettype wire

// File: tb/tb_control_vector_stage_reg.sv
// ============================================================================
// tb_control_vector_stage_reg : scoreboard bench for the control-vector register
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_control_vector_stage_reg;

  typedef struct {
    string       name;
    logic [23:0] exp;
  } exp_t;

  localparam logic [23:0] C_VEC_A = 24'h555555;
  localparam logic [23:0] C_ONES  = 24'hFFFFFF;
  localparam logic [23:0] C_ZERO  = 24'h000000;

  logic        clk;
  logic        rst_n;
  logic        nop;
  logic [23:0] in_v;
  logic [23:0] out_v;

  exp_t exp_q[$];
  int   n_checks;
  int   n_pass;
  bit   drv_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  control_vector_stage_reg dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .nop            (nop),
    .in_PC_LD       (in_v[0]),  .in_PC_INC      (in_v[1]),
    .in_PC_MUX_SEL  (in_v[2]),  .in_SP_LD       (in_v[3]),
    .in_SP_INCR     (in_v[4]),  .in_SP_DECR     (in_v[5]),
    .in_RF_WR       (in_v[6]),  .in_RF_WR_SEL   (in_v[7]),
    .in_ALU_OPY_SEL (in_v[8]),  .in_ALU_SEL     (in_v[9]),
    .in_SCR_WE      (in_v[10]), .in_SCR_DATA_SE (in_v[11]),
    .in_SCR_ADDR_SE (in_v[12]), .in_FLG_C_SET   (in_v[13]),
    .in_FLG_C_CLR   (in_v[14]), .in_FLG_C_LD    (in_v[15]),
    .in_FLG_Z_LD    (in_v[16]), .in_FLG_LD_SEL  (in_v[17]),
    .in_FLG_SHAD_LD (in_v[18]), .in_I_SET       (in_v[19]),
    .in_I_CLR       (in_v[20]), .in_IO_STRB     (in_v[21]),
    .in_BRANCH_TYPE (in_v[22]), .in_rst         (in_v[23]),
    .out_PC_LD       (out_v[0]),  .out_PC_INC      (out_v[1]),
    .out_PC_MUX_SEL  (out_v[2]),  .out_SP_LD       (out_v[3]),
    .out_SP_INCR     (out_v[4]),  .out_SP_DECR     (out_v[5]),
    .out_RF_WR       (out_v[6]),  .out_RF_WR_SEL   (out_v[7]),
    .out_ALU_OPY_SEL (out_v[8]),  .out_ALU_SEL     (out_v[9]),
    .out_SCR_WE      (out_v[10]), .out_SCR_DATA_SE (out_v[11]),
    .out_SCR_ADDR_SE (out_v[12]), .out_FLG_C_SET   (out_v[13]),
    .out_FLG_C_CLR   (out_v[14]), .out_FLG_C_LD    (out_v[15]),
    .out_FLG_Z_LD    (out_v[16]), .out_FLG_LD_SEL  (out_v[17]),
    .out_FLG_SHAD_LD (out_v[18]), .out_I_SET       (out_v[19]),
    .out_I_CLR       (out_v[20]), .out_IO_STRB     (out_v[21]),
    .out_BRANCH_TYPE (out_v[22]), .out_rst         (out_v[23])
  );

  // Drive one edge's worth of inputs on the falling edge and queue what must
  // appear just after the following rising edge.
  task automatic apply(input string name, input logic r_n, input logic n,
                       input logic [23:0] vec, input logic [23:0] exp);
    exp_t e;
    @(negedge clk);
    rst_n = r_n;
    nop   = n;
    in_v  = vec;
    e.name = name;
    e.exp  = exp;
    exp_q.push_back(e);
  endtask

  // Monitor: the register presents a new vector after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (out_v === e.exp) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got %06h expected %06h", e.name, out_v, e.exp);
        end
      end
    end
  end

  initial begin
    logic [23:0] one;
    n_checks = 0;
    n_pass   = 0;
    drv_done = 1'b0;
    rst_n    = 1'b0;
    nop      = 1'b0;
    in_v     = C_ZERO;

    apply("reset_all_ones", 1'b0, 1'b0, C_ONES, C_ZERO);
    apply("reset_hold",     1'b0, 1'b0, C_ONES, C_ZERO);
    apply("pass_A",         1'b1, 1'b0, C_VEC_A, C_VEC_A);
    apply("pass_notA",      1'b1, 1'b0, ~C_VEC_A, 24'hAAAAAA);

    apply("bubble_nop1",    1'b1, 1'b1, C_VEC_A, C_ZERO);
    apply("bubble_nop0",    1'b1, 1'b0, C_VEC_A, C_VEC_A);
    apply("bubble_nop1b",   1'b1, 1'b1, C_VEC_A, C_ZERO);
    apply("bubble_nop0b",   1'b1, 1'b0, C_VEC_A, C_VEC_A);
    apply("nop_kills_rst",  1'b1, 1'b1, C_ONES, C_ZERO);

    apply("prio_rst_nop0",  1'b0, 1'b0, C_ONES, C_ZERO);
    apply("prio_release",   1'b1, 1'b0, C_ONES, C_ONES);
    apply("prio_rst_nop1",  1'b0, 1'b1, C_ONES, C_ZERO);
    apply("illegal_combo",  1'b1, 1'b0, 24'h000030, 24'h000030);

    for (int i = 0; i < 24; i++) begin
      one = 24'h1 << i;
      apply($sformatf("walk1_bit%0d", i), 1'b1, 1'b0, one, one);
    end

    apply("stream_A0",      1'b1, 1'b0, C_VEC_A, C_VEC_A);
    apply("stream_A1",      1'b1, 1'b0, C_VEC_A, C_VEC_A);
    apply("midrun_reset",   1'b0, 1'b0, C_VEC_A, C_ZERO);
    apply("after_reset_A",  1'b1, 1'b0, C_VEC_A, C_VEC_A);
    apply("after_reset_A2", 1'b1, 1'b0, C_VEC_A, C_VEC_A);

    // Inputs changing mid-cycle must not disturb the held output.
    @(negedge clk);
    in_v = C_ONES;
    #2;
    n_checks++;
    if (out_v === C_VEC_A) n_pass++;
    else $display("FAIL hold_between_edges: got %06h expected %06h", out_v, C_VEC_A);
    in_v = C_VEC_A;

    drv_done = 1'b1;
  end

  initial begin
    int guard;
    wait (drv_done);
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    repeat (2) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
